ps2_sim_injector: RTL and testbench
===================================

PS2_SIM_INJECTOR -- requirements
Module: ps2_sim_injector

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent PS/2 device channels (0 = keyboard, 1 = mouse).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning scancode FIFO entries per channel (power of 2, >= 2).
REQ-003 The block SHALL have parameter CLK_DIV, default 4, meaning the clk cycles per PS/2 clock half-period (>= 2).
REQ-004 The block SHALL have parameter GAP_CYCLES, default 8, meaning the idle clk cycles between frames (>= 1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port code_i, input, NUM_CH*8 bits: the scancode per channel, where channel n is [8n+7:8n].
REQ-008 The block SHALL have port strobe_i, input, NUM_CH bits: a one-cycle push request per channel.
REQ-009 The block SHALL have port err_i, input, NUM_CH bits: when high with strobe, that frame is sent with a corrupted parity bit.
REQ-010 The block SHALL have port ps2clk_o, output, NUM_CH bits: the device clock line (1 = released/high).
REQ-011 The block SHALL have port ps2data_o, output, NUM_CH bits: the device data line (1 = released/high).
REQ-012 The block SHALL have port busy_o, output, NUM_CH bits: high while the FIFO is non-empty or the FSM is not IDLE.
REQ-013 The block SHALL have port overflow_o, output, NUM_CH bits: a sticky flag for a dropped push.

Function
REQ-014 Each channel SHALL be fully independent: its own FIFO, FSM, counters and flags; channels do not interact.
REQ-015 The FIFO entry SHALL be 9 bits {err, code}, written on clk when strobe_i[n]=1.
REQ-016 A push SHALL be accepted iff count < FIFO_DEPTH, or a pop occurs in the same cycle (full + simultaneous push/pop keeps count = FIFO_DEPTH).
REQ-017 A rejected push SHALL be dropped, set overflow_o[n]=1 until reset, and leave FIFO contents unchanged.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-019 The FSM states SHALL be IDLE, BIT_HI, BIT_LO and GAP.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop one entry, load an 11-bit frame, set bit index 0 and go to BIT_HI next cycle.
REQ-021 The frame SHALL be sent in the order start=0, data[0]..data[7] (LSB first), parity, stop=1.
REQ-022 Parity SHALL be odd, i.e. ~^data; when the entry's err bit is set, ~(~^data) SHALL be sent instead.
REQ-023 In BIT_HI, ps2clk_o=1 and ps2data_o=current bit SHALL hold for exactly CLK_DIV cycles, after which the FSM goes to BIT_LO.
REQ-024 ps2data_o SHALL change only on entry to BIT_HI, never while ps2clk_o=0.
REQ-025 In BIT_LO, ps2clk_o=0 SHALL hold for exactly CLK_DIV cycles; if the bit index < 10, the index increments and the FSM goes to BIT_HI, else it goes to GAP.
REQ-026 In GAP, ps2clk_o=1 and ps2data_o=1 SHALL hold for GAP_CYCLES cycles, after which the FSM goes to IDLE.
REQ-027 In IDLE, ps2clk_o=1 and ps2data_o=1.
REQ-028 Frame latency SHALL be: a strobe into an empty, idle channel gives the first BIT_HI (data=0) 2 cycles after the strobe edge.
REQ-029 The frame period SHALL be 1 + 22*CLK_DIV + GAP_CYCLES cycles.
REQ-030 Back-to-back FIFO entries SHALL always be separated by a full GAP; no frame is ever truncated except by reset.
REQ-031 Pushes arriving during a frame SHALL be queued and SHALL NOT affect the frame in flight.
REQ-032 busy_o SHALL fall in the cycle the FSM enters IDLE with an empty FIFO.

Reset
REQ-033 While reset_i=1 at clk: FIFOs are emptied, FSM=IDLE, counters=0, overflow_o=0, busy_o=0, ps2clk_o=all 1, ps2data_o=all 1.
REQ-034 Reset asserted mid-frame SHALL abort the frame; lines read 1 in the cycle after the reset edge, and the aborted entry is not resent.
REQ-035 A strobe in the same cycle as reset_i SHALL be ignored.

Verification
REQ-036 Normal frame: ch0 code 0x1C, err=0, CLK_DIV=4 -> data sampled at each ps2clk fall = 0,0,0,1,1,1,0,0,0,0,1; 11 falling edges; busy_o low after 1+88+8 cycles.
REQ-037 Parity error: ch0 code 0xF0, err=1 -> parity bit 0 (correct value 1); all other bits are unchanged.
REQ-038 Overflow: 9 strobes on consecutive cycles into idle ch1 (depth 8) -> the first pops immediately, so 8 are queued; a 10th strobe while the FIFO is full -> overflow_o[1]=1; exactly 9 frames are emitted.
REQ-039 Channel independence: ch0 0xAA and ch1 0x55 strobed in the same cycle -> both frames are concurrent and cycle-aligned with correct bits; each channel's busy_o is independent.
REQ-040 Reset mid-frame: reset at the 5th BIT_LO of ch0 with 2 entries queued -> next cycle lines=1, busy_o=0, no further edges for 200 cycles.
REQ-041 Full with simultaneous push/pop: FIFO full, push in the IDLE pop cycle -> accepted, overflow_o stays 0, count stays 8.

Source files
------------

// File: rtl/ps2_sim_injector.sv
// Simulated PS/2 device: per-channel scancode FIFO that replays each entry as an 11-bit
// device-to-host frame on open-drain style clock/data lines, with optional parity corruption.
module ps2_sim_injector #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [NUM_CH*8-1:0] code_i,
  input  logic [NUM_CH-1:0]   strobe_i,
  input  logic [NUM_CH-1:0]   err_i,
  output logic [NUM_CH-1:0]   ps2clk_o,
  output logic [NUM_CH-1:0]   ps2data_o,
  output logic [NUM_CH-1:0]   busy_o,
  output logic [NUM_CH-1:0]   overflow_o
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  localparam logic [AW:0]   FullCnt = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DivLast = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GapLast = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBitHi, StBitLo, StGap} state_e;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          push, pop;
    logic [8:0]    head;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [10:0]   frame_q, frame_d;

    assign head = mem_q[rptr_q];
    assign pop  = (state_q == StIdle) && (count_q != '0);
    // A full FIFO still accepts a push in the cycle it is being popped.
    assign push = strobe_i[ch] && ((count_q != FullCnt) || pop);

    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wptr_q] <= {err_i[ch], code_i[ch*8 +: 8]};
      end
    end

    always_ff @(posedge clk) begin
      if (reset_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop)  rptr_q <= rptr_q + AW'(1);
        if (strobe_i[ch] && !push) ovf_q <= 1'b1;
        if (push && !pop) begin
          count_q <= count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
          count_q <= count_q - (AW + 1)'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        idx_q   <= '0;
        frame_q <= '1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        frame_q <= frame_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      case (state_q)
        StIdle: begin
          if (pop) begin
            // {stop, parity, data, start}; err flips the odd-parity bit.
            frame_d = {1'b1, (~^head[7:0]) ^ head[8], head[7:0], 1'b0};
            idx_d   = '0;
            cnt_d   = '0;
            state_d = StBitHi;
          end
        end
        StBitHi: begin
          if (cnt_q == DivLast) begin
            cnt_d   = '0;
            state_d = StBitLo;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StBitLo: begin
          if (cnt_q == DivLast) begin
            cnt_d = '0;
            if (idx_q < 4'd10) begin
              idx_d   = idx_q + 4'd1;
              state_d = StBitHi;
            end else begin
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Data only moves when idx changes, which happens on entry to StBitHi.
    assign ps2clk_o[ch]   = (state_q != StBitLo);
    assign ps2data_o[ch]  = ((state_q == StBitHi) || (state_q == StBitLo)) ? frame_q[idx_q] : 1'b1;
    assign busy_o[ch]     = (count_q != '0) || (state_q != StIdle);
    assign overflow_o[ch] = ovf_q;
  end

endmodule

// File: tb/tb_ps2_sim_injector.sv
// Bench for ps2_sim_injector: frame table on ch0, hand-built corner sequences, and a
// randomized phase, all against a cycle-level reference model of the line waveforms.
module tb_ps2_sim_injector;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam int CD    = 4;
  localparam int GAP   = 8;
  localparam int BITS  = 22 * CD;
  localparam int PER   = BITS + GAP;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] code_i;
  logic [1:0]  strobe_i, err_i;
  logic [1:0]  ps2clk_o, ps2data_o, busy_o, overflow_o;

  ps2_sim_injector #(
    .NUM_CH    (NCH),
    .FIFO_DEPTH(DEPTH),
    .CLK_DIV   (CD),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .code_i    (code_i),
    .strobe_i  (strobe_i),
    .err_i     (err_i),
    .ps2clk_o  (ps2clk_o),
    .ps2data_o (ps2data_o),
    .busy_o    (busy_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: queue of pending entries plus position within the frame in flight.
  logic [8:0]  mq    [NCH][$];
  bit          m_act [NCH];
  int          m_pos [NCH];
  logic [10:0] m_frm [NCH];
  bit          m_ovf [NCH];
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit         pp, acc, par;
    logic [8:0] ent;
    for (int c = 0; c < NCH; c++) begin
      if (reset_i) begin
        mq[c].delete();
        m_act[c] = 1'b0;
        m_pos[c] = 0;
        m_ovf[c] = 1'b0;
      end else begin
        pp  = !m_act[c] && (mq[c].size() > 0);
        acc = strobe_i[c] && ((mq[c].size() < DEPTH) || pp);
        if (strobe_i[c] && !acc) m_ovf[c] = 1'b1;
        if (m_act[c]) begin
          m_pos[c]++;
          if (m_pos[c] == PER) m_act[c] = 1'b0;
        end else if (pp) begin
          ent = mq[c].pop_front();
          par = (($countones(ent[7:0]) % 2) == 0) ^ ent[8];
          m_frm[c] = {1'b1, par, ent[7:0], 1'b0};
          m_act[c] = 1'b1;
          m_pos[c] = 0;
        end
        if (acc) mq[c].push_back({err_i[c], code_i[c*8 +: 8]});
      end
    end
  end

  function automatic logic [3:0] expect_out(input int c);
    logic k, d, b;
    k = 1'b1;
    d = 1'b1;
    b = m_act[c] || (mq[c].size() > 0);
    if (m_act[c] && (m_pos[c] < BITS)) begin
      k = (m_pos[c] % (2 * CD)) < CD;
      d = m_frm[c][m_pos[c] / (2 * CD)];
    end
    return {k, d, b, m_ovf[c]};
  endfunction

  // Line monitor: data sampled at each ps2clk fall, plus per-cycle model comparison.
  bit rx     [NCH][$];
  int edges  [NCH] = '{0, 0};
  bit prev_k [NCH] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        if (prev_k[c] && !ps2clk_o[c]) begin
          rx[c].push_back(ps2data_o[c]);
          edges[c]++;
        end
        prev_k[c] = ps2clk_o[c];
        check($sformatf("cycle_ch%0d_clk_data_busy_ovf", c),
              {28'd0, ps2clk_o[c], ps2data_o[c], busy_o[c], overflow_o[c]},
              {28'd0, expect_out(c)});
      end
    end
  end

  function automatic logic [10:0] rx_val(input int c);
    logic [10:0] v;
    v = '0;
    for (int i = 0; i < 11 && i < rx[c].size(); i++) v[i] = rx[c][i];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [7:0] code, input logic err);
    code_i[c*8 +: 8] = code;
    err_i[c]         = err;
    strobe_i[c]      = 1'b1;
    tick();
    strobe_i[c]      = 1'b0;
  endtask

  task automatic wait_idle(input int c, input int budget, output int n);
    n = 0;
    while (busy_o[c] && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check($sformatf("wait_idle_ch%0d_timeout", c), {31'd0, busy_o[c]}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  code;
    logic        err;
    logic [10:0] frame;  // bit i = i-th bit on the wire
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, k, e0;
    vecs[0] = '{8'h1C, 1'b0, 11'h438};
    vecs[1] = '{8'hF0, 1'b1, 11'h5E0};
    vecs[2] = '{8'hF0, 1'b0, 11'h7E0};
    vecs[3] = '{8'h00, 1'b0, 11'h600};
    vecs[4] = '{8'hFF, 1'b0, 11'h7FE};
    vecs[5] = '{8'h01, 1'b1, 11'h602};

    reset_i  = 1'b1;
    strobe_i = '0;
    err_i    = '0;
    code_i   = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("reset_state", {24'd0, ps2clk_o, ps2data_o, busy_o, overflow_o}, 32'h000000F0);
    reset_i = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      rx[0].delete();
      push(0, vecs[i].code, vecs[i].err);
      wait_idle(0, 300, n);
      check($sformatf("frame%0d_bits", i), {21'd0, rx_val(0)}, {21'd0, vecs[i].frame});
      check($sformatf("frame%0d_edges", i), rx[0].size(), 11);
      check($sformatf("frame%0d_busy_cycles", i), n, 97);
    end

    // Both channels strobed together.
    rx[0].delete();
    rx[1].delete();
    code_i   = {8'h55, 8'hAA};
    err_i    = 2'b00;
    strobe_i = 2'b11;
    tick();
    strobe_i = 2'b00;
    wait_idle(0, 300, n);
    wait_idle(1, 300, n);
    check("indep_ch0_bits", {21'd0, rx_val(0)}, 32'h754);
    check("indep_ch1_bits", {21'd0, rx_val(1)}, 32'h6AA);
    push(0, 8'h12, 1'b0);
    check("indep_busy", {30'd0, busy_o}, 32'd1);
    wait_idle(0, 300, n);

    // Overflow on ch1: 9 accepted back-to-back, 10th dropped.
    rx[1].delete();
    for (int i = 0; i < 9; i++) push(1, 8'(8'h30 + i), 1'(i % 2));
    push(1, 8'hEE, 1'b0);
    check("ovf_set_ch1", {31'd0, overflow_o[1]}, 32'd1);
    check("ovf_clear_ch0", {31'd0, overflow_o[0]}, 32'd0);
    wait_idle(1, 1200, n);
    check("ovf_frames_bits", rx[1].size(), 99);

    // Reset at the 5th BIT_LO of ch0 with two entries queued.
    e0 = edges[0];
    push(0, 8'h21, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h23, 1'b0);
    k = 0;
    while ((edges[0] - e0) < 5 && k < 200) begin
      tick();
      k++;
    end
    check("rst_reached_5th_fall", edges[0] - e0, 5);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("rst_lines_busy", {29'd0, ps2clk_o[0], ps2data_o[0], busy_o[0]}, 32'd6);
    check("rst_ovf_cleared", {30'd0, overflow_o}, 32'd0);
    e0 = edges[0];
    repeat (200) tick();
    check("rst_no_edges", edges[0] - e0, 0);
    check("rst_busy_low", {30'd0, busy_o}, 32'd0);

    // Full FIFO, push landing exactly in the IDLE pop cycle.
    rx[0].delete();
    for (int i = 0; i < 9; i++) push(0, 8'(8'h40 + i), 1'b0);
    k = 0;
    while (!(m_act[0] && m_pos[0] == PER - 1) && k < 300) begin
      tick();
      k++;
    end
    check("pp_reached_gap_end", k < 300, 1);
    tick();
    push(0, 8'h5A, 1'b1);
    check("pp_no_overflow", {31'd0, overflow_o[0]}, 32'd0);
    wait_idle(0, 1300, n);
    check("pp_frames_bits", rx[0].size(), 110);

    // Randomized traffic with alternating light and bursty phases and rare resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        strobe_i[c] = ((cyc / 500) % 2 == 1) ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 39) == 0);
      end
      code_i  = 16'($urandom());
      err_i   = 2'($urandom());
      reset_i = ($urandom_range(0, 999) == 0);
      tick();
    end
    strobe_i = '0;
    reset_i  = 1'b0;
    wait_idle(0, 1200, n);
    wait_idle(1, 1200, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
